// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch unit: datapath width, the NOP
// encoding loaded into the IR on reset or abort, and the fetch FSM states.
package riscv_pkg;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;  // addi x0, x0, 0

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } ifu_state_t;

  function automatic logic is_word_aligned(input logic [1:0] low_bits);
    return low_bits == 2'b00;
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instr_fetch_unit_if #(
  parameter int unsigned XLEN = riscv_pkg::XLEN
);

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/ifu_watchdog.sv
// Fetch watchdog: counts cycles spent waiting for a memory acknowledge and
// flags expiry on the last allowed cycle, so the abort lands on the edge
// that completes TIMEOUT_CYCLES waiting cycles.
module ifu_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic start_i,
  input  logic run_i,
  output logic expired_o
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = '0;
    end else if (run_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = run_i && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/instr_fetch_unit.sv
// Multi-cycle instruction fetch stage: PC register, req/ack handshake to
// instruction memory and IR. Optional fetch watchdog under FETCH_TIMEOUT_EN.
module instr_fetch_unit #(
  parameter int unsigned      XLEN           = riscv_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC       = '0,
  parameter int unsigned      TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_en,
  input  logic                pc_en,
  input  logic [XLEN-1:0]     pc_next,
  instr_fetch_unit_if.master  imem,
  output logic [31:0]         instr,
  output logic [XLEN-1:0]     pc,
  output logic                instr_valid,
  output logic                fetch_busy,
  output logic                fault
);

  import riscv_pkg::*;

  ifu_state_t      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pend_q, pend_d;
  logic            pend_valid_q, pend_valid_d;
  logic            req_q, req_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [31:0]     instr_q, instr_d;
  logic            valid_q, valid_d;
  logic            fault_q, fault_d;
  logic            abort;

`ifdef FETCH_TIMEOUT_EN
  ifu_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .rst       (rst),
    .start_i   ((state_q == IDLE) && fetch_en),
    .run_i     ((state_q == WAIT) && !imem.imem_ack),
    .expired_o (abort)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
  assign abort          = 1'b0;
`endif

  // NOTE: every _d is given its hold value before the case statement so no
  // path through the block leaves a variable unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    req_d        = req_q;
    addr_d       = addr_q;
    instr_d      = instr_q;
    valid_d      = 1'b0;
    fault_d      = fault_q;

    unique case (state_q)
      IDLE: begin
        // The fetch address is taken from pc_q, so a coincident pc_en
        // only affects the following fetch.
        if (fetch_en) begin
          state_d = WAIT;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
        if (pc_en) begin
          if (is_word_aligned(pc_next[1:0])) pc_d = pc_next;
          else                               fault_d = 1'b1;
        end
      end

      WAIT: begin
        if (pc_en) begin
          if (is_word_aligned(pc_next[1:0])) begin
            pend_d       = pc_next;
            pend_valid_d = 1'b1;
          end else begin
            fault_d = 1'b1;
          end
        end
        if (imem.imem_ack || abort) begin
          state_d = IDLE;
          req_d   = 1'b0;
          valid_d = 1'b1;
          instr_d = imem.imem_ack ? imem.imem_rdata : NOP_INSTR;
          if (!imem.imem_ack) fault_d = 1'b1;
          // A PC update deferred during the fetch takes effect as we return.
          if (pend_valid_d) pc_d = pend_d;
          pend_valid_d = 1'b0;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      pc_q         <= RESET_PC;
      pend_q       <= RESET_PC;
      pend_valid_q <= 1'b0;
      req_q        <= 1'b0;
      addr_q       <= RESET_PC;
      instr_q      <= NOP_INSTR;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      req_q        <= req_d;
      addr_q       <= addr_d;
      instr_q      <= instr_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;
  assign instr          = instr_q;
  assign pc             = pc_q;
  assign instr_valid    = valid_q;
  assign fetch_busy     = (state_q == WAIT);
  assign fault          = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: reset, handshake latency, delayed ack,
// deferred PC update, misalignment fault, stale ack and reset during a fetch.
module tb_instr_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        pc_en;
  logic [31:0] pc_next;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_valid;
  logic        fetch_busy;
  logic        fault;

  int n_checks = 0;
  int n_errors = 0;

  instr_fetch_unit_if #(.XLEN(32)) imem_bus ();

  instr_fetch_unit #(
    .XLEN           (32),
    .RESET_PC       (32'h0000_0000),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_en    (fetch_en),
    .pc_en       (pc_en),
    .pc_next     (pc_next),
    .imem        (imem_bus),
    .instr       (instr),
    .pc          (pc),
    .instr_valid (instr_valid),
    .fetch_busy  (fetch_busy),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst                 = 1'b0;
    fetch_en            = 1'b0;
    pc_en               = 1'b0;
    pc_next             = '0;
    imem_bus.imem_ack   = 1'b0;
    imem_bus.imem_rdata = '0;

    // Reset values
    #12;
    check("rst_req",   {31'b0, imem_bus.imem_req}, 32'd0);
    check("rst_addr",  imem_bus.imem_addr, 32'h0);
    check("rst_pc",    pc, 32'h0);
    check("rst_instr", instr, NOP);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
    check("rst_busy",  {31'b0, fetch_busy}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    step();

    // 1: minimum-latency fetch
    fetch_en = 1'b1;
    step();
    check("t1_req",   {31'b0, imem_bus.imem_req}, 32'd1);
    check("t1_addr",  imem_bus.imem_addr, 32'h0);
    check("t1_busy",  {31'b0, fetch_busy}, 32'd1);
    check("t1_valid_early", {31'b0, instr_valid}, 32'd0);
    fetch_en = 1'b0;
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h0050_0093;
    step();
    check("t1_valid", {31'b0, instr_valid}, 32'd1);
    check("t1_instr", instr, 32'h0050_0093);
    check("t1_req_drop", {31'b0, imem_bus.imem_req}, 32'd0);
    check("t1_idle", {31'b0, fetch_busy}, 32'd0);
    imem_bus.imem_ack = 1'b0;
    step();
    check("t1_valid_pulse", {31'b0, instr_valid}, 32'd0);

    // 2: ack delayed 5 cycles
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("t2_req",   {31'b0, imem_bus.imem_req}, 32'd1);
      check("t2_addr",  imem_bus.imem_addr, 32'h0);
      check("t2_busy",  {31'b0, fetch_busy}, 32'd1);
      check("t2_valid", {31'b0, instr_valid}, 32'd0);
      step();
    end
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h00A0_0113;
    step();
    check("t2_valid_ack", {31'b0, instr_valid}, 32'd1);
    check("t2_instr", instr, 32'h00A0_0113);
    imem_bus.imem_ack = 1'b0;
    step();
    check("t2_valid_pulse", {31'b0, instr_valid}, 32'd0);

    // 3: pc_en during WAIT is deferred until ack
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    pc_en = 1'b1;
    pc_next = 32'h100;
    step();
    pc_en = 1'b0;
    check("t3_pc_held", pc, 32'h0);
    check("t3_busy", {31'b0, fetch_busy}, 32'd1);
    step();
    check("t3_pc_held2", pc, 32'h0);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h0000_0033;
    step();
    imem_bus.imem_ack = 1'b0;
    check("t3_pc_applied", pc, 32'h100);
    check("t3_valid", {31'b0, instr_valid}, 32'd1);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    check("t3_addr_new", imem_bus.imem_addr, 32'h100);
    check("t3_req_new", {31'b0, imem_bus.imem_req}, 32'd1);
    // Later pc_en in the same WAIT overwrites the pending value
    pc_en = 1'b1;
    pc_next = 32'h200;
    step();
    pc_next = 32'h104;
    step();
    pc_en = 1'b0;
    check("t3_pc_held3", pc, 32'h100);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h0010_8093;
    step();
    imem_bus.imem_ack = 1'b0;
    check("t3_pc_overwrite", pc, 32'h104);
    check("t3_instr2", instr, 32'h0010_8093);

    // 4: misaligned pc_next, then fetch_en + pc_en together
    check("t4_fault_pre", {31'b0, fault}, 32'd0);
    pc_en = 1'b1;
    pc_next = 32'h102;
    step();
    pc_en = 1'b0;
    check("t4_fault", {31'b0, fault}, 32'd1);
    check("t4_pc_unchanged", pc, 32'h104);
    fetch_en = 1'b1;
    pc_en = 1'b1;
    pc_next = 32'h108;
    step();
    fetch_en = 1'b0;
    pc_en = 1'b0;
    check("t4_addr_old_pc", imem_bus.imem_addr, 32'h104);
    check("t4_pc_new", pc, 32'h108);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h0020_8113;
    step();
    imem_bus.imem_ack = 1'b0;
    check("t4_instr", instr, 32'h0020_8113);
    check("t4_fault_sticky", {31'b0, fault}, 32'd1);
    step();
    // Stale ack while IDLE is ignored
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_bus.imem_ack = 1'b0;
    check("t4_stale_valid", {31'b0, instr_valid}, 32'd0);
    check("t4_stale_instr", instr, 32'h0020_8113);
    check("t4_stale_busy", {31'b0, fetch_busy}, 32'd0);

`ifdef FETCH_TIMEOUT_EN
    // 6: no ack, abort after 4 WAIT cycles
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_busy", {31'b0, fetch_busy}, 32'd1);
      check("t6_valid_early", {31'b0, instr_valid}, 32'd0);
    end
    step();
    check("t6_valid", {31'b0, instr_valid}, 32'd1);
    check("t6_instr", instr, NOP);
    check("t6_fault", {31'b0, fault}, 32'd1);
    check("t6_req", {31'b0, imem_bus.imem_req}, 32'd0);
    check("t6_idle", {31'b0, fetch_busy}, 32'd0);
`else
    // Without the watchdog a fetch waits indefinitely
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      check("nt_busy", {31'b0, fetch_busy}, 32'd1);
      check("nt_valid", {31'b0, instr_valid}, 32'd0);
    end
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h0030_0193;
    step();
    imem_bus.imem_ack = 1'b0;
    check("nt_valid_ack", {31'b0, instr_valid}, 32'd1);
    check("nt_instr", instr, 32'h0030_0193);
`endif
    step();

    // 5: reset mid-WAIT, ack during and right after reset is ignored
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    check("t5_req_before", {31'b0, imem_bus.imem_req}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("t5_req_async", {31'b0, imem_bus.imem_req}, 32'd0);
    check("t5_instr_nop", instr, NOP);
    check("t5_fault_clr", {31'b0, fault}, 32'd0);
    check("t5_pc_reset", pc, 32'h0);
    imem_bus.imem_ack = 1'b1;
    imem_bus.imem_rdata = 32'h1111_1111;
    step();
    rst = 1'b1;
    step();
    check("t5_no_valid", {31'b0, instr_valid}, 32'd0);
    check("t5_instr_kept", instr, NOP);
    check("t5_idle", {31'b0, fetch_busy}, 32'd0);
    imem_bus.imem_ack = 1'b0;
    step();
    check("t5_no_valid2", {31'b0, instr_valid}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
